load_store_unit: RTL and testbench

- Initiator side of the banked byte-lane data memory port.
- Accepts load/store requests from the processor datapath over a valid/ready handshake and drives the memory signals: address, write data, write enable, read enable and DataType.
- Waits out the fixed read latency, then sign- or zero-extends the returned byte or half-word.
- Returns a single-entry response over valid/ready. It sits between the execute stage and the data memory.

---
 rtl/ls_pkg.sv | 29 ++
 rtl/load_extend.sv | 25 ++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared definitions for the load/store unit: DataType codes, FSM states and
// the alignment rule used to reject misaligned half/word accesses.
package ls_pkg;

  localparam logic [1:0] DT_WORD     = 2'b00;
  localparam logic [1:0] DT_BYTE     = 2'b01;
  localparam logic [1:0] DT_HALF     = 2'b10;
  localparam logic [1:0] DT_WORD_ALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lsState_e;

  // Half needs addr[0]==0, word needs addr[1:0]==0, bytes are always aligned.
  function automatic logic isMisaligned(input logic [1:0] dataType,
                                        input logic [1:0] addrLow);
    logic mis;
    case (dataType)
      DT_BYTE: mis = 1'b0;
      DT_HALF: mis = addrLow[0];
      default: mis = (addrLow != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: keeps the low byte or half-word, clears
// the upper bits and optionally replicates the sign bit. Words pass through.
// Also used by the writeback path, so it carries no state.
module load_extend
  import ls_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rawData,
  input  logic [1:0]            dataType,
  input  logic                  isSigned,
  output logic [DATA_WIDTH-1:0] extData
);

  // Select lane width and fill the upper bits with zero or the sign bit.
  always_comb begin
    extData = rawData;
    case (dataType)
      DT_BYTE: extData = {{(DATA_WIDTH-8){isSigned & rawData[7]}}, rawData[7:0]};
      DT_HALF: extData = {{(DATA_WIDTH-16){isSigned & rawData[15]}}, rawData[15:0]};
      default: extData = rawData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the byte-lane data memory port. Accepts one load/store at
// a time, drives the memory strobes, waits out the read latency and returns a
// single registered response (extended load data or a misalignment error).
module load_store_unit
  import ls_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 8,
  parameter int READ_LATENCY     = 1,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_type,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_esc,
  output logic                  mem_read,
  output logic [1:0]            mem_type,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  lsState_e              state_r, nextState_s;
  logic [2:0]            count_r, nextCount_s;
  logic                  signed_r, nextSigned_s;
  logic [ADDR_WIDTH-1:0] nextAddr_s;
  logic [DATA_WIDTH-1:0] nextWdata_s;
  logic [1:0]            nextType_s;
  logic                  nextEsc_s, nextRead_s;
  logic                  nextRespValid_s, nextRespErr_s;
  logic [DATA_WIDTH-1:0] nextRespData_s;
  logic [DATA_WIDTH-1:0] extData_s;

  assign req_ready = (state_r == IDLE);

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) uExtend (
    .rawData  (mem_rdata),
    .dataType (mem_type),
    .isSigned (signed_r),
    .extData  (extData_s)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    nextState_s     = state_r;
    nextCount_s     = count_r;
    nextSigned_s    = signed_r;
    nextAddr_s      = mem_addr;
    nextWdata_s     = mem_wdata;
    nextType_s      = mem_type;
    nextEsc_s       = 1'b0;
    nextRead_s      = mem_read;
    nextRespValid_s = resp_valid;
    nextRespErr_s   = resp_err;
    nextRespData_s  = resp_data;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          nextAddr_s   = req_addr;
          nextWdata_s  = req_wdata;
          nextType_s   = req_type;
          nextSigned_s = req_signed;
          if ((ALLOW_MISALIGNED == 0) && isMisaligned(req_type, req_addr[1:0])) begin
            nextState_s     = RESP;
            nextRespValid_s = 1'b1;
            nextRespErr_s   = 1'b1;
            nextRespData_s  = '0;
          end else if (req_write) begin
            nextState_s = WRITE;
            nextEsc_s   = 1'b1;
          end else begin
            nextState_s = READ;
            nextRead_s  = 1'b1;
            nextCount_s = LAT_INIT;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WRITE: begin
        // The write strobe was raised on accept and drops here after one cycle.
        nextState_s     = RESP;
        nextRespValid_s = 1'b1;
        nextRespErr_s   = 1'b0;
        nextRespData_s  = '0;
      end
      READ: begin
        if (count_r == 3'd0) begin
          nextState_s     = RESP;
          nextRead_s      = 1'b0;
          nextRespValid_s = 1'b1;
          nextRespErr_s   = 1'b0;
          nextRespData_s  = extData_s;
        end else begin
          nextCount_s = count_r - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          nextState_s     = IDLE;
          nextRespValid_s = 1'b0;
          nextRespErr_s   = 1'b0;
        end else begin
          nextState_s = RESP;
        end
      end
      default: begin
        nextState_s     = IDLE;
        nextRead_s      = 1'b0;
        nextRespValid_s = 1'b0;
        nextRespErr_s   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      count_r    <= 3'd0;
      signed_r   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_type   <= 2'b00;
      mem_esc    <= 1'b0;
      mem_read   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state_r    <= nextState_s;
      count_r    <= nextCount_s;
      signed_r   <= nextSigned_s;
      mem_addr   <= nextAddr_s;
      mem_wdata  <= nextWdata_s;
      mem_type   <= nextType_s;
      mem_esc    <= nextEsc_s;
      mem_read   <= nextRead_s;
      resp_valid <= nextRespValid_s;
      resp_err   <= nextRespErr_s;
      resp_data  <= nextRespData_s;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: instance 0 (latency 1, misaligned allowed) and instance 1
// (latency 3, misaligned rejected) share the request bus; each has its own
// memory model, expectation queue and response monitor.
module tb_load_store_unit;
  import ls_pkg::*;

  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        reqWrite, reqSigned;
  logic [1:0]  reqType;
  logic [7:0]  reqAddr;
  logic [31:0] reqWdata;
  logic        reqValid [2];
  logic        reqReady [2];
  logic        respValid[2];
  logic        respReady[2];
  logic        respErr  [2];
  logic        memEsc   [2];
  logic        memRead  [2];
  logic [31:0] respData [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];
  logic [7:0]  memAddr  [2];
  logic [1:0]  memType  [2];

  logic [31:0] tbMem [2][256];
  int          rdCnt [2];
  logic [32:0] expQ0[$];
  logic [32:0] expQ1[$];
  logic [32:0] exp0, exp1;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  load_store_unit #(.READ_LATENCY(RL0), .ALLOW_MISALIGNED(1)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite),
    .req_type(reqType), .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_data(respData[0]),
    .resp_err(respErr[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
    .mem_esc(memEsc[0]), .mem_read(memRead[0]), .mem_type(memType[0]), .mem_rdata(memRdata[0])
  );

  load_store_unit #(.READ_LATENCY(RL1), .ALLOW_MISALIGNED(0)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite),
    .req_type(reqType), .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_data(respData[1]),
    .resp_err(respErr[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
    .mem_esc(memEsc[1]), .mem_read(memRead[1]), .mem_type(memType[1]), .mem_rdata(memRdata[1])
  );

  // Memory model: word per byte address, counts read cycles to enforce latency.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (memEsc[i]) tbMem[i][memAddr[i]] <= memWdata[i];
      if (memRead[i]) rdCnt[i] <= rdCnt[i] + 1;
      else rdCnt[i] <= 0;
    end
  end

  // Read data is only valid in the cycle the configured latency expires.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (memRead[i] && rdCnt[i] == ((i == 0) ? RL0 : RL1) - 1)
        memRdata[i] = tbMem[i][memAddr[i]];
      else
        memRdata[i] = 32'hA5A5_A5A5;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the expected response at each handshake.
  always @(negedge clock) begin
    #1;
    if (respValid[0] && respReady[0]) begin
      checks++;
      if (expQ0.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected actual=%b_%h required=none", respErr[0], respData[0]);
      end else begin
        exp0 = expQ0.pop_front();
        if ({respErr[0], respData[0]} !== exp0) begin
          errors++;
          $display("FAIL resp0 actual=%b_%h required=%b_%h", respErr[0], respData[0], exp0[32], exp0[31:0]);
        end
      end
    end
    if (respValid[1] && respReady[1]) begin
      checks++;
      if (expQ1.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected actual=%b_%h required=none", respErr[1], respData[1]);
      end else begin
        exp1 = expQ1.pop_front();
        if ({respErr[1], respData[1]} !== exp1) begin
          errors++;
          $display("FAIL resp1 actual=%b_%h required=%b_%h", respErr[1], respData[1], exp1[32], exp1[31:0]);
        end
      end
    end
  end

  task automatic doReq(input int k, input logic wr, input logic [1:0] ty, input logic sg,
                       input logic [7:0] ad, input logic [31:0] wd, input logic [31:0] expData,
                       input logic expErr, input int expLat, input int hold);
    int lat, escN, rdN, rl, guard;
    rl = (k == 0) ? RL0 : RL1;
    guard = 0;
    while (!reqReady[k] && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("ready_before_req", 32'(reqReady[k]), 32'd1);
    reqWrite = wr; reqType = ty; reqSigned = sg; reqAddr = ad; reqWdata = wd;
    reqValid[k]  = 1'b1;
    respReady[k] = (hold == 0);
    @(posedge clock);
    if (k == 0) expQ0.push_back({expErr, expData});
    else        expQ1.push_back({expErr, expData});
    @(negedge clock);
    reqValid[k] = 1'b0;
    lat = 1; escN = 0; rdN = 0;
    while (!respValid[k] && lat < 40) begin
      if (memEsc[k]) begin
        escN++;
        chk("esc_addr", 32'(memAddr[k]), 32'(ad));
        chk("esc_wdata", memWdata[k], wd);
      end
      if (memRead[k]) begin
        rdN++;
        chk("read_addr", 32'(memAddr[k]), 32'(ad));
        chk("read_type", 32'(memType[k]), 32'(ty));
      end
      chk("busy_ready", 32'(reqReady[k]), 32'd0);
      @(negedge clock);
      lat++;
    end
    chk("latency", lat, expLat);
    chk("esc_cycles", escN, (wr && !expErr) ? 32'd1 : 32'd0);
    chk("read_cycles", rdN, (!wr && !expErr) ? rl : 0);
    for (int c = 0; c < hold; c++) begin
      chk("hold_valid", 32'(respValid[k]), 32'd1);
      chk("hold_data", respData[k], expData);
      chk("hold_ready", 32'(reqReady[k]), 32'd0);
      @(negedge clock);
    end
    respReady[k] = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((expQ0.size() != 0 || expQ1.size() != 0 || !reqReady[0] || !reqReady[1]) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_q0", expQ0.size(), 32'd0);
    chk("drain_q1", expQ1.size(), 32'd0);
  endtask

  initial begin
    int acc[$];
    reset_n = 1'b0;
    reqValid = '{1'b0, 1'b0};
    respReady = '{1'b0, 1'b0};
    reqWrite = 1'b0; reqType = DT_WORD; reqSigned = 1'b0; reqAddr = 8'h00; reqWdata = 32'h0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(reqReady[i]), 32'd1);
      chk("rst_resp_valid", 32'(respValid[i]), 32'd0);
      chk("rst_mem_esc", 32'(memEsc[i]), 32'd0);
      chk("rst_mem_read", 32'(memRead[i]), 32'd0);
      chk("rst_resp_data", respData[i], 32'd0);
      chk("rst_mem_addr", 32'(memAddr[i]), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);

    // Instance 0: latency 1, misaligned passed through.
    doReq(0, 1'b1, DT_WORD,     1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_WORD,     1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
    doReq(0, 1'b1, DT_WORD,     1'b0, 8'h20, 32'h00000080, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_BYTE,     1'b1, 8'h20, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_BYTE,     1'b0, 8'h20, 32'h0,        32'h00000080, 1'b0, 2, 0);
    doReq(0, 1'b1, DT_WORD,     1'b0, 8'h24, 32'h00008001, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_HALF,     1'b1, 8'h24, 32'h0,        32'hFFFF8001, 1'b0, 2, 0);
    doReq(0, 1'b1, DT_WORD_ALT, 1'b0, 8'h30, 32'hABCD12F0, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_HALF,     1'b0, 8'h30, 32'h0,        32'h000012F0, 1'b0, 2, 1);
    doReq(0, 1'b0, DT_BYTE,     1'b1, 8'h30, 32'h0,        32'hFFFFFFF0, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_WORD_ALT, 1'b1, 8'h30, 32'h0,        32'hABCD12F0, 1'b0, 2, 0);
    doReq(0, 1'b1, DT_WORD,     1'b0, 8'h03, 32'h1234ABCD, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_HALF,     1'b0, 8'h03, 32'h0,        32'h0000ABCD, 1'b0, 2, 0);
    doReq(0, 1'b1, DT_WORD,     1'b0, 8'hFF, 32'h0BADF00D, 32'h00000000, 1'b0, 2, 0);
    doReq(0, 1'b0, DT_WORD,     1'b0, 8'hFF, 32'h0,        32'h0BADF00D, 1'b0, 2, 0);

    // Instance 1: latency 3, misaligned rejected.
    doReq(1, 1'b0, DT_HALF,     1'b0, 8'h03, 32'h0,        32'h00000000, 1'b1, 1, 0);
    doReq(1, 1'b1, DT_WORD,     1'b0, 8'h02, 32'h11111111, 32'h00000000, 1'b1, 1, 0);
    doReq(1, 1'b1, DT_WORD,     1'b0, 8'h40, 32'h12345678, 32'h00000000, 1'b0, 2, 0);
    doReq(1, 1'b0, DT_WORD,     1'b0, 8'h40, 32'h0,        32'h12345678, 1'b0, 4, 4);
    doReq(1, 1'b0, DT_BYTE,     1'b1, 8'h40, 32'h0,        32'h00000078, 1'b0, 4, 0);
    drain();

    // Back-to-back: request held high, response always accepted.
    reqWrite = 1'b0; reqType = DT_WORD; reqSigned = 1'b0; reqAddr = 8'h10; reqWdata = 32'h0;
    respReady[0] = 1'b1;
    reqValid[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (reqReady[0]) begin
        acc.push_back(c);
        expQ0.push_back({1'b0, 32'hDEADBEEF});
      end
      @(negedge clock);
    end
    reqValid[0] = 1'b0;
    chk("b2b_accepts", acc.size(), 32'd3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 32'd3);
      chk("b2b_gap2", acc[2] - acc[1], 32'd3);
    end
    drain();

    // Reset in the middle of a latency-3 read on instance 1.
    reqWrite = 1'b0; reqType = DT_WORD; reqAddr = 8'h40;
    respReady[1] = 1'b1;
    reqValid[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reqValid[1] = 1'b0;
    chk("rst_mid_read_active", 32'(memRead[1]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_mem_read", 32'(memRead[1]), 32'd0);
    chk("rst_async_resp_valid", 32'(respValid[1]), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_release_ready", 32'(reqReady[1]), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rst_no_stale_valid", 32'(respValid[1]), 32'd0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
